// File: rtl/cpu_package.sv
// cpu_package: shared instruction format and encoder state types.
package cpu_package;
    typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} instruction_type_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} encoder_state_t;
endpackage

// File: rtl/instruction_pack.sv
// instruction_pack: combinational field packing and immediate range check.
module instruction_pack
    import cpu_package::*;
(
    input  instruction_type_t type_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic [31:0]       word_o,
    output logic              error_o
);
    logic i_ok, b_ok;
    always_comb begin
        i_ok    = (&imm_i[31:11]) || !(|imm_i[31:11]);
        b_ok    = ((&imm_i[31:12]) || !(|imm_i[31:12])) && !imm_i[0];
        word_o  = {7'd0, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        error_o = 1'b1;
        case (type_i)
            R_TYPE: begin
                word_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                error_o = 1'b0;
            end
            I_TYPE: begin
                word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                error_o = !i_ok;
            end
            S_TYPE: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                error_o = !i_ok;
            end
            B_TYPE: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
                error_o = !b_ok;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: batch sequencer wrapping instruction_pack with
// valid/ready streams, address generation and a sticky error flag.
module instruction_encoder
    import cpu_package::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       base_address,
    input  logic [15:0]       count,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              in_valid,
    output logic              in_ready,
    input  instruction_type_t in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instruction,
    output logic [31:0]       out_address,
    output logic              out_error
);
    encoder_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, out_instr_q, out_instr_d, out_addr_q, out_addr_d;
    logic [15:0] cnt_q, cnt_d, acc_q, acc_d;
    logic        out_valid_q, out_valid_d, out_err_q, out_err_d, err_q, err_d;
    logic [31:0] pack_word;
    logic        pack_err, in_fire, out_fire, go;

    instruction_pack u_pack (
        .type_i   (in_type),
        .opcode_i (in_opcode),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .imm_i    (in_immediate),
        .word_o   (pack_word),
        .error_o  (pack_err)
    );

    assign in_ready = (state_q == RUN) && (acc_q < cnt_q) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign go       = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (count == 16'd0) ? DONE : RUN;
            RUN:     if (out_fire && acc_q == cnt_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
        cnt_d       = go ? count : cnt_q;
        acc_d       = go ? 16'd0 : acc_q + 16'(in_fire);
        addr_d      = go ? base_address : addr_q + (in_fire ? 32'd4 : 32'd0);
        out_valid_d = in_fire || (out_valid_q && !out_ready);
        out_instr_d = in_fire ? pack_word : out_instr_q;
        out_addr_d  = in_fire ? addr_q : out_addr_q;
        out_err_d   = in_fire ? pack_err : out_err_q;
        err_d       = go ? 1'b0 : (err_q || (out_fire && out_err_q));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_q       <= err_d;
        end
    end

    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign error           = err_q;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_address     = out_addr_q;
    assign out_error       = out_err_q;
endmodule
